// File: rtl/display_pkg.sv
// Shared display constants: driver modes, request kinds, scheduler states and
// the message codes the message converter also uses.
package display_pkg;

    localparam logic [1:0] MODE_TEXT    = 2'b00;
    localparam logic [1:0] MODE_NUM     = 2'b01;
    localparam logic [1:0] MODE_TEXTNUM = 2'b10;
    localparam logic [1:0] MODE_CLOCK   = 2'b11;

    localparam logic [1:0] KIND_TEXT    = 2'b00;
    localparam logic [1:0] KIND_NUM     = 2'b01;
    localparam logic [1:0] KIND_TEXTNUM = 2'b10;
    localparam logic [1:0] KIND_RSVD    = 2'b11;

    localparam logic [4:0] MSG_BLANK = 5'd0;
    localparam logic [4:0] MSG_HELLO = 5'd1;
    localparam logic [4:0] MSG_ERROR = 5'd2;
    localparam logic [4:0] MSG_ALARM = 5'd3;
    localparam logic [4:0] MSG_SET   = 5'd4;
    localparam logic [4:0] MSG_DONE  = 5'd5;
    localparam logic [4:0] MSG_FULL  = 5'd6;
    localparam logic [4:0] MSG_EMPTY = 5'd7;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic [4:0]  code;
        logic [10:0] data;
    } msg_t;

    // Reserved kind falls back to plain text.
    function automatic logic [1:0] kind_to_mode(input logic [1:0] kind);
        logic [1:0] m;
        case (kind)
            KIND_NUM:     m = MODE_NUM;
            KIND_TEXTNUM: m = MODE_TEXTNUM;
            default:      m = MODE_TEXT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: tick is high during the last cycle of each second;
// restart holds the count at zero so a new second starts on release.
module sec_tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == TERM);

endmodule

// File: rtl/display_scheduler.sv
// Display scheduler: shows wall-clock by default and holds posted messages for
// HOLD_SEC seconds each. Define DISPLAY_PREEMPT_EN for replace-on-arrival.
module display_scheduler
    import display_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int HOLD_SEC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [1:0]  msg_kind,
    input  logic [4:0]  msg_code,
    input  logic [10:0] msg_data,
    input  logic        msg_clear,
    output logic [1:0]  mode,
    output logic [4:0]  message_code,
    output logic [10:0] data,
    output logic        busy
);

    localparam int SEC_W = $clog2(HOLD_SEC + 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(HOLD_SEC - 1);

    state_t           r_state, w_state_next;
    msg_t             r_show, w_show_next;
    msg_t             r_pend, w_pend_next;
    logic             r_pend_full, w_pend_full_next;
    logic [SEC_W-1:0] r_sec_cnt, w_sec_cnt_next;

    logic w_tick;
    logic w_restart;
    logic w_ready;
    logic w_accept;
    logic w_expire;
    msg_t w_in_msg;

    sec_tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_sec_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

`ifdef DISPLAY_PREEMPT_EN
    assign w_ready = !msg_clear;
`else
    assign w_ready = !r_pend_full && !msg_clear;
`endif

    assign w_accept = msg_valid && w_ready;
    assign w_expire = (r_state == SHOW) && w_tick && (r_sec_cnt == SEC_LAST);
    assign w_in_msg = '{mode: kind_to_mode(msg_kind), code: msg_code, data: msg_data};

    always_comb begin
        w_state_next     = r_state;
        w_show_next      = r_show;
        w_pend_next      = r_pend;
        w_pend_full_next = r_pend_full;
        w_sec_cnt_next   = r_sec_cnt;
        w_restart        = 1'b0;

        if (msg_clear) begin
            w_state_next     = IDLE;
            w_show_next.mode = MODE_CLOCK;
            w_pend_full_next = 1'b0;
            w_sec_cnt_next   = '0;
            w_restart        = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // Prescaler parked at zero so the first second is a full one.
                    w_restart = 1'b1;
                    if (w_accept) begin
                        w_state_next   = SHOW;
                        w_show_next    = w_in_msg;
                        w_sec_cnt_next = '0;
                    end
                end
                SHOW: begin
                    if (w_tick) begin
                        w_sec_cnt_next = r_sec_cnt + SEC_W'(1);
                    end
`ifdef DISPLAY_PREEMPT_EN
                    if (w_accept) begin
                        w_show_next    = w_in_msg;
                        w_sec_cnt_next = '0;
                        w_restart      = 1'b1;
                    end else if (w_expire) begin
                        w_state_next     = IDLE;
                        w_show_next.mode = MODE_CLOCK;
                        w_sec_cnt_next   = '0;
                        w_restart        = 1'b1;
                    end
`else
                    if (w_expire) begin
                        w_sec_cnt_next = '0;
                        w_restart      = 1'b1;
                        if (r_pend_full) begin
                            w_show_next      = r_pend;
                            w_pend_full_next = 1'b0;
                        end else if (w_accept) begin
                            // Hand over straight from the input; no clock frame in between.
                            w_show_next = w_in_msg;
                        end else begin
                            w_state_next     = IDLE;
                            w_show_next.mode = MODE_CLOCK;
                        end
                    end else if (w_accept) begin
                        w_pend_next      = w_in_msg;
                        w_pend_full_next = 1'b1;
                    end
`endif
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_show      <= '{mode: MODE_CLOCK, code: 5'd0, data: 11'd0};
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_sec_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_show      <= w_show_next;
            r_pend      <= w_pend_next;
            r_pend_full <= w_pend_full_next;
            r_sec_cnt   <= w_sec_cnt_next;
        end
    end

    assign msg_ready    = w_ready;
    assign mode         = r_show.mode;
    assign message_code = r_show.code;
    assign data         = r_show.data;
    assign busy         = (r_state == SHOW);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler with a 4-cycle second and 2-second hold (8 cycles):
// directed vector table, reset sequences, then random traffic against a queue model.
module tb_display_scheduler;

    localparam int CLK_FREQ = 4;
    localparam int HOLD_SEC = 2;
    localparam int HOLD     = CLK_FREQ * HOLD_SEC;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_kind;
    logic [4:0]  msg_code;
    logic [10:0] msg_data;
    logic        msg_clear;
    logic [1:0]  mode;
    logic [4:0]  message_code;
    logic [10:0] data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    display_scheduler #(
        .CLK_FREQ(CLK_FREQ),
        .HOLD_SEC(HOLD_SEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_kind     (msg_kind),
        .msg_code     (msg_code),
        .msg_data     (msg_data),
        .msg_clear    (msg_clear),
        .mode         (mode),
        .message_code (message_code),
        .data         (data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: on-screen record, countdown, FIFO of waiting requests
    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  code;
        logic [10:0] data;
    } rec_t;

    bit          m_busy;
    logic [1:0]  m_mode;
    logic [4:0]  m_code;
    logic [10:0] m_data;
    int          m_left;
    rec_t        m_pend[$];

    function automatic logic [1:0] map_kind(input logic [1:0] k);
        if (k == 2'b01) return 2'b01;
        if (k == 2'b10) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_ready();
`ifdef DISPLAY_PREEMPT_EN
        return !msg_clear;
`else
        return (m_pend.size() == 0) && !msg_clear;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_mode = 2'b11;
        m_code = '0;
        m_data = '0;
        m_left = 0;
        m_pend.delete();
    endtask

    task automatic m_show(input rec_t r);
        m_mode = r.mode;
        m_code = r.code;
        m_data = r.data;
        m_left = HOLD;
        m_busy = 1'b1;
    endtask

    task automatic model_edge();
        rec_t inr;
        bit   acc;
        inr = '{map_kind(msg_kind), msg_code, msg_data};
        acc = msg_valid && m_ready();
        if (msg_clear) begin
            m_busy = 1'b0;
            m_mode = 2'b11;
            m_left = 0;
            m_pend.delete();
        end else if (!m_busy) begin
            if (acc) m_show(inr);
        end else begin
            m_left--;
`ifdef DISPLAY_PREEMPT_EN
            if (acc) m_show(inr);
            else if (m_left == 0) begin
                m_busy = 1'b0;
                m_mode = 2'b11;
            end
`else
            if (m_left == 0) begin
                if (m_pend.size() > 0) m_show(m_pend.pop_front());
                else if (acc) m_show(inr);
                else begin
                    m_busy = 1'b0;
                    m_mode = 2'b11;
                end
            end else if (acc) begin
                m_pend.push_back(inr);
            end
`endif
        end
    endtask

    // ---------------- stimulus helpers
    task automatic drive(input logic v, input logic [1:0] k, input logic [4:0] c,
                         input logic [10:0] d, input logic clr);
        msg_valid = v;
        msg_kind  = k;
        msg_code  = c;
        msg_data  = d;
        msg_clear = clr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  k;
        logic [4:0]  c;
        logic [10:0] d;
        logic        clr;
        logic        rdy;
        logic [1:0]  e_mode;
        logic [4:0]  e_code;
        logic [10:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [1:0] k, input logic [4:0] c, input logic [10:0] d,
                       input logic clr, input logic rdy, input logic [1:0] em, input logic [4:0] ec,
                       input logic [10:0] ed, input logic eb);
        vec_t x;
        x = '{v, k, c, d, clr, rdy, em, ec, ed, eb};
        vecs.push_back(x);
    endtask

    task automatic idle(input int n, input logic rdy, input logic [1:0] em, input logic [4:0] ec,
                        input logic [10:0] ed, input logic eb);
        for (int i = 0; i < n; i++) add(1'b0, 2'b00, 5'd0, 11'd0, 1'b0, rdy, em, ec, ed, eb);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 5'd0, 11'd0, 1'b0);
        model_reset();

        // vectors: each row is one cycle of inputs, ready before the edge, outputs after it
        idle(1, 1, 2'b11, 5'd0, 11'd0, 0);
`ifdef DISPLAY_PREEMPT_EN
        add(1, 2'b00, 5'd5, 11'd1, 0, 1, 2'b00, 5'd5, 11'd1, 1);
        idle(2, 1, 2'b00, 5'd5, 11'd1, 1);
        add(1, 2'b10, 5'd7, 11'd12, 0, 1, 2'b10, 5'd7, 11'd12, 1);
        idle(HOLD - 1, 1, 2'b10, 5'd7, 11'd12, 1);
        idle(1, 1, 2'b11, 5'd7, 11'd12, 0);
        add(1, 2'b01, 5'd1, 11'd1, 1, 0, 2'b11, 5'd7, 11'd12, 0);
        idle(1, 1, 2'b11, 5'd7, 11'd12, 0);
`else
        // single number message, then back to clock after exactly HOLD cycles
        add(1, 2'b01, 5'd0, 11'h3E7, 0, 1, 2'b01, 5'd0, 11'h3E7, 1);
        idle(HOLD - 1, 1, 2'b01, 5'd0, 11'h3E7, 1);
        idle(1, 1, 2'b11, 5'd0, 11'h3E7, 0);
        // A then queued B
        add(1, 2'b00, 5'd5, 11'd1, 0, 1, 2'b00, 5'd5, 11'd1, 1);
        idle(1, 1, 2'b00, 5'd5, 11'd1, 1);
        add(1, 2'b10, 5'd7, 11'd12, 0, 1, 2'b00, 5'd5, 11'd1, 1);
        idle(HOLD - 3, 0, 2'b00, 5'd5, 11'd1, 1);
        idle(1, 0, 2'b10, 5'd7, 11'd12, 1);
        idle(HOLD - 1, 1, 2'b10, 5'd7, 11'd12, 1);
        idle(1, 1, 2'b11, 5'd7, 11'd12, 0);
        // bypass: request lands on the expiry edge, reserved kind shows as text
        add(1, 2'b01, 5'd3, 11'h400, 0, 1, 2'b01, 5'd3, 11'h400, 1);
        idle(HOLD - 1, 1, 2'b01, 5'd3, 11'h400, 1);
        add(1, 2'b11, 5'd9, 11'h055, 0, 1, 2'b00, 5'd9, 11'h055, 1);
        idle(HOLD - 1, 1, 2'b00, 5'd9, 11'h055, 1);
        idle(1, 1, 2'b11, 5'd9, 11'h055, 0);
        // clear with pending full and valid high; then clear+valid while idle
        add(1, 2'b00, 5'd1, 11'd2, 0, 1, 2'b00, 5'd1, 11'd2, 1);
        add(1, 2'b01, 5'd2, 11'd3, 0, 1, 2'b00, 5'd1, 11'd2, 1);
        add(1, 2'b10, 5'd4, 11'd5, 1, 0, 2'b11, 5'd1, 11'd2, 0);
        idle(2, 1, 2'b11, 5'd1, 11'd2, 0);
        add(1, 2'b10, 5'd4, 11'd5, 1, 0, 2'b11, 5'd1, 11'd2, 0);
        idle(1, 1, 2'b11, 5'd1, 11'd2, 0);
`endif

        // reset values while held
        repeat (2) step();
        check("rst_mode", 32'(mode), 32'(2'b11));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_ready", 32'(msg_ready), 32'(1'b1));
        check("rst_data", 32'(data), 32'(11'd0));
        check("rst_code", 32'(message_code), 32'(5'd0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].k, vecs[i].c, vecs[i].d, vecs[i].clr);
            check($sformatf("vec%0d_ready", i), 32'(msg_ready), 32'(vecs[i].rdy));
            step();
            check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].e_mode));
            check($sformatf("vec%0d_code", i), 32'(message_code), 32'(vecs[i].e_code));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].e_data));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end

        // async reset in the middle of a message takes effect without a clock edge
        drive(1'b1, 2'b10, 5'd11, 11'h123, 1'b0);
        step();
        drive(1'b0, 2'b00, 5'd0, 11'd0, 1'b0);
        step();
        step();
        check("pre_rst_busy", 32'(busy), 32'(1'b1));
        rst = 1'b1;
        #1;
        check("async_rst_mode", 32'(mode), 32'(2'b11));
        check("async_rst_busy", 32'(busy), 32'(1'b0));
        check("async_rst_data", 32'(data), 32'(11'd0));
        check("async_rst_code", 32'(message_code), 32'(5'd0));
        check("async_rst_ready", 32'(msg_ready), 32'(1'b1));
        step();
        rst = 1'b0;
        model_reset();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(2, 0) == 0), 2'($urandom), 5'($urandom), 11'($urandom),
                  ($urandom_range(49, 0) == 0));
            check("rnd_ready", 32'(msg_ready), 32'(m_ready()));
            step();
            check("rnd_mode", 32'(mode), 32'(m_mode));
            check("rnd_code", 32'(message_code), 32'(m_code));
            check("rnd_data", 32'(data), 32'(m_data));
            check("rnd_busy", 32'(busy), 32'(m_busy));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
